// File: rtl/snn_pkg.sv
// Shared SNN definitions: data widths, LIF state encoding and the 8-bit clamp
// that is also used by the synaptic current calculator.
package snn_pkg;

    localparam int V_W   = 8;   // membrane potential / current width
    localparam int SUM_W = 10;  // intermediate leak+integrate width, wide enough for no overflow

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } lif_state_e;

    // Clamp a SUM_W-bit signed value into the signed 8-bit range [-128, 127].
    function automatic logic signed [V_W-1:0] sat8(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        hi = 10'sd127;
        lo = -10'sd128;
        if (s > hi) begin
            return 8'sd127;
        end else if (s < lo) begin
            return -8'sd128;
        end else begin
            return s[V_W-1:0];
        end
    endfunction

endpackage

// File: rtl/membrane_update.sv
// Combinational membrane step: leak, integrate the input current, saturate
// to 8 bits and compare against the firing threshold.
module membrane_update
    import snn_pkg::*;
(
    input  logic signed [V_W-1:0] v_i,
    input  logic signed [V_W-1:0] current_i,
    input  logic signed [V_W-1:0] threshold_i,
    input  logic        [2:0]     decay_i,
    output logic signed [V_W-1:0] v_next_o,
    output logic                  fire_o
);

    logic signed [V_W-1:0]   leak;
    logic signed [SUM_W-1:0] v_ext;
    logic signed [SUM_W-1:0] leak_ext;
    logic signed [SUM_W-1:0] cur_ext;
    logic signed [SUM_W-1:0] sum;

    // Leak (arithmetic shift, rounds toward -inf), integrate, clamp, compare.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no
        // path leaves one unassigned and no latch is inferred.
        leak = '0;
        if (decay_i != 3'd0) begin
            leak = v_i >>> decay_i;
        end
        v_ext    = {{(SUM_W-V_W){v_i[V_W-1]}},       v_i};
        leak_ext = {{(SUM_W-V_W){leak[V_W-1]}},      leak};
        cur_ext  = {{(SUM_W-V_W){current_i[V_W-1]}}, current_i};
        sum      = v_ext - leak_ext + cur_ext;
        v_next_o = sat8(sum);
        fire_o   = (v_next_o >= threshold_i);
    end

endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron. One membrane update per enabled cycle,
// results visible one edge later with a one-cycle out_valid strobe. After a
// spike the neuron may sit in a refractory hold for a programmable number of
// enabled steps, ignoring its input.
module lif_neuron_core
    import snn_pkg::*;
#(
    parameter int                     REF_W   = 4,
    parameter logic signed [V_W-1:0]  V_RESET = 8'sd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic signed [V_W-1:0] input_current,
    input  logic signed [V_W-1:0] threshold,
    input  logic        [2:0]     decay,
    input  logic        [REF_W-1:0] refractory_period,
    output logic signed [V_W-1:0] membrane_potential,
    output logic                  spike_out,
    output logic                  refractory_active,
    output logic                  out_valid
);

    lif_state_e              state_q;
    logic signed [V_W-1:0]   v_q;
    logic [REF_W-1:0]        ref_cnt_q;
    logic                    spike_q;
    logic                    valid_q;

    logic signed [V_W-1:0]   v_d;
    logic                    fire;

    membrane_update u_membrane_update (
        .v_i         (v_q),
        .current_i   (input_current),
        .threshold_i (threshold),
        .decay_i     (decay),
        .v_next_o    (v_d),
        .fire_o      (fire)
    );

    // FSM, refractory counter and registered outputs; reset overrides enable.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here updates from
        // the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= ST_INTEGRATE;
            v_q       <= V_RESET;
            ref_cnt_q <= '0;
            spike_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            spike_q <= 1'b0;
            valid_q <= enable;
            if (enable) begin
                case (state_q)
                    ST_INTEGRATE: begin
                        if (fire) begin
                            spike_q <= 1'b1;
                            v_q     <= V_RESET;
                            if (refractory_period != '0) begin
                                ref_cnt_q <= refractory_period;
                                state_q   <= ST_REFRACTORY;
                            end
                        end else begin
                            v_q <= v_d;
                        end
                    end
                    ST_REFRACTORY: begin
                        v_q <= V_RESET;
                        if (ref_cnt_q <= REF_W'(1)) begin
                            ref_cnt_q <= '0;
                            state_q   <= ST_INTEGRATE;
                        end else begin
                            ref_cnt_q <= ref_cnt_q - REF_W'(1);
                        end
                    end
                    default: begin
                        state_q   <= ST_INTEGRATE;
                        ref_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign membrane_potential = v_q;
    assign spike_out          = spike_q;
    assign refractory_active  = (state_q == ST_REFRACTORY);
    assign out_valid          = valid_q;

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core with hand-computed expected values.
module tb_lif_neuron_core;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic signed [7:0] input_current = '0;
    logic signed [7:0] threshold = '0;
    logic        [2:0] decay = '0;
    logic        [3:0] refractory_period = '0;
    logic signed [7:0] membrane_potential;
    logic              spike_out;
    logic              refractory_active;
    logic              out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    lif_neuron_core #(.REF_W(4), .V_RESET(8'sd0)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .input_current      (input_current),
        .threshold          (threshold),
        .decay              (decay),
        .refractory_period  (refractory_period),
        .membrane_potential (membrane_potential),
        .spike_out          (spike_out),
        .refractory_active  (refractory_active),
        .out_valid          (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Check all four outputs after an edge.
    task automatic expect_out(input string tag, input int v, input int spk,
                              input int vld, input int refr);
        check({tag, ".v"},     int'(membrane_potential), v);
        check({tag, ".spike"}, int'(spike_out),          spk);
        check({tag, ".valid"}, int'(out_valid),          vld);
        check({tag, ".ref"},   int'(refractory_active),  refr);
    endtask

    // Drive one cycle's inputs at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic en, input logic signed [7:0] cur);
        @(negedge clk);
        enable        = en;
        input_current = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        reset         = 1'b1;
        enable        = en;
        input_current = 8'sd50;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset(1'b0);
        expect_out("reset", 0, 0, 0, 0);

        // 1. Plain integration to threshold
        threshold = 8'sd100; decay = 3'd0; refractory_period = 4'd0;
        step(1'b1, 8'sd30);  expect_out("t1.s1", 30, 0, 1, 0);
        step(1'b1, 8'sd30);  expect_out("t1.s2", 60, 0, 1, 0);
        step(1'b1, 8'sd30);  expect_out("t1.s3", 90, 0, 1, 0);
        step(1'b1, 8'sd30);  expect_out("t1.s4", 0,  1, 1, 0);
        step(1'b0, 8'sd30);  expect_out("t1.idle", 0, 0, 0, 0);

        // 2. Leak: V - (V>>>1) from 64
        threshold = 8'sd127;
        step(1'b1, 8'sd64);  check("t2.load", int'(membrane_potential), 64);
        decay = 3'd1;
        step(1'b1, 8'sd0);   check("t2.l32", int'(membrane_potential), 32);
        step(1'b1, 8'sd0);   check("t2.l16", int'(membrane_potential), 16);
        step(1'b1, 8'sd0);   check("t2.l8",  int'(membrane_potential), 8);
        step(1'b1, 8'sd0);   check("t2.l4",  int'(membrane_potential), 4);
        step(1'b1, 8'sd0);   check("t2.l2",  int'(membrane_potential), 2);
        step(1'b1, 8'sd0);   check("t2.l1",  int'(membrane_potential), 1);
        // 1 - (1>>>1) = 1 - 0 = 1: a positive residue of 1 does not leak away
        step(1'b1, 8'sd0);   check("t2.l1h", int'(membrane_potential), 1);
        decay = 3'd0;
        step(1'b1, -8'sd2);  check("t2.neg1", int'(membrane_potential), -1);
        // -1 - (-1>>>1) = -1 - (-1) = 0
        decay = 3'd1;
        step(1'b1, 8'sd0);   check("t2.negleak", int'(membrane_potential), 0);
        decay = 3'd0;

        // 3. Saturation: 100 + 127 clamps to 127, which meets threshold 127
        step(1'b1, 8'sd100);  check("t3.v100", int'(membrane_potential), 100);
        step(1'b1, 8'sd127);  expect_out("t3.satfire", 0, 1, 1, 0);
        step(1'b1, -8'sd100); check("t3.vm100", int'(membrane_potential), -100);
        step(1'b1, -8'sd128); check("t3.clamp1", int'(membrane_potential), -128);
        step(1'b1, -8'sd128); check("t3.clamp2", int'(membrane_potential), -128);

        // 4. Refractory hold of 3 enabled steps, gap not counted
        do_reset(1'b0);
        threshold = 8'sd10; refractory_period = 4'd3;
        step(1'b1, 8'sd20);  expect_out("t4.fire", 0, 1, 1, 1);
        refractory_period = 4'd15;  // must not alter the loaded count
        step(1'b1, 8'sd50);  expect_out("t4.r1", 0, 0, 1, 1);
        step(1'b0, 8'sd50);  expect_out("t4.gap", 0, 0, 0, 1);
        step(1'b1, 8'sd50);  expect_out("t4.r2", 0, 0, 1, 1);
        step(1'b1, 8'sd50);  expect_out("t4.r3", 0, 0, 1, 0);
        refractory_period = 4'd3;
        step(1'b1, 8'sd7);   expect_out("t4.resume", 7, 0, 1, 0);

        // 5. Reset during the second refractory step
        step(1'b1, 8'sd20);  expect_out("t5.fire", 0, 1, 1, 1);
        step(1'b1, 8'sd50);  expect_out("t5.r1", 0, 0, 1, 1);
        do_reset(1'b1);      // reset wins over enable
        expect_out("t5.rst", 0, 0, 0, 0);
        step(1'b1, 8'sd5);   expect_out("t5.after", 5, 0, 1, 0);

        // 6. No refractory, threshold 0: fires on every enabled step
        refractory_period = 4'd0; threshold = 8'sd0;
        step(1'b1, 8'sd5);   expect_out("t6.s1", 0, 1, 1, 0);
        step(1'b1, 8'sd5);   expect_out("t6.s2", 0, 1, 1, 0);
        step(1'b0, 8'sd5);   expect_out("t6.gap", 0, 0, 0, 0);
        step(1'b1, 8'sd5);   expect_out("t6.s3", 0, 1, 1, 0);
        step(1'b0, 8'sd5);   expect_out("t6.end", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
